gcd_seq_ctrl: RTL and testbench
===============================

# gcd_seq_ctrl

Sequencer between the APB register file and the GCD compute core. Accepts the register file's start pulse, opcode and timing controls, and issues a single-cycle start to the core. Tracks core latency and optionally pads completion to a programmed cycle count so results emerge in constant time. Returns a done pulse and status word to the register file, which owns interrupt generation.

## Interface

Parameters:
- CNT_W, 12: width of the cycle counter, CYCLE_COUNT and ELAPSED.
- TIMEOUT, 2**CNT_W-1: counter value at which a pending core operation is abandoned.

Ports:
- CLK  in  1  sole clock; all state changes on its rising edge.
- RESET  in  1  synchronous, active-high reset.
- START_PULSE  in  1  one-cycle start request from the register file.
- OPCODE  in  3  operation select; sampled with START_PULSE.
- CONSTANT_TIME  in  1  pad-to-CYCLE_COUNT enable; sampled with START_PULSE.
- CYCLE_COUNT  in  CNT_W  constant-time target N; sampled with START_PULSE.
- CORE_START  out  1  one-cycle start to the GCD core.
- CORE_OP  out  3  latched opcode to the core; held stable while BUSY.
- CORE_DONE  in  1  one-cycle completion from the core.
- DONE_PULSE  out  1  one-cycle completion to the register file.
- BUSY  out  1  high from the cycle after an accepted start through the DONE_PULSE cycle.
- STATUS  out  2  completion code; valid from DONE_PULSE until the next accepted start.
- ELAPSED  out  CNT_W  core latency c of the last operation.

## Operation

- States: IDLE, ISSUE, WAIT, PAD, DONE.
- IDLE:
  - START_PULSE latches OPCODE, CONSTANT_TIME and CYCLE_COUNT, and clears STATUS.
  - A legal opcode moves the block to ISSUE.
  - An illegal opcode (above OP_MAX) moves it to DONE with STATUS=ILLEGAL. CORE_START is never asserted.
- ISSUE: CORE_START=1 and cnt=0. Always moves to WAIT.
- WAIT: cnt increments by 1 each cycle.
  - On CORE_DONE, ELAPSED latches cnt (=c).
  - If CT=1 and c<N, go to PAD. Otherwise go to DONE.
  - If CT=1 and c>N at CORE_DONE, STATUS=OVERRUN.
  - If cnt reaches TIMEOUT without CORE_DONE, go to DONE with STATUS=TIMEOUT and ELAPSED=TIMEOUT.
- PAD: cnt keeps incrementing. When cnt==N, go to DONE.
- DONE: DONE_PULSE=1. Always returns to IDLE.
- STATUS codes: OK=0, ILLEGAL=1, OVERRUN=2, TIMEOUT=3.
- START_PULSE outside IDLE is ignored: no latch, no state change. This includes the DONE cycle.
- CORE_DONE outside WAIT is ignored.
- CT=0, or CT=1 with N=0, gives no padding.
- The counter is unsigned CNT_W bits and saturates at TIMEOUT. It never wraps.

## Timing

- Reset values: state IDLE, CORE_START=0, CORE_OP=0, DONE_PULSE=0, BUSY=0, STATUS=OK, ELAPSED=0, cnt=0.
- RESET mid-operation returns to IDLE next cycle. No DONE_PULSE is generated. The core is reset by the same RESET.
- START_PULSE accepted at cycle s:
  - CORE_START is high at cycle s+1.
  - Cycle s+1+k has cnt=k.
  - CORE_DONE at cnt=c (c≥1).
- DONE_PULSE cycle:
  - Legal opcode, no timeout: s+2+max(c, N_eff), where N_eff = N if CT=1, else 0.
  - Timeout: s+2+TIMEOUT.
  - Illegal opcode: s+1.
- Latency from CORE_DONE to DONE_PULSE is 1 cycle when no padding applies.
- BUSY is high on cycles s+1 through the DONE_PULSE cycle inclusive.
- The next START_PULSE can be accepted at DONE_PULSE+1.

## Structure

- Shared package gcd_pkg holds:
  - Opcode constants and OP_MAX=3'd3.
  - State enum.
  - STATUS code constants.
  - Default CNT_W.
- Sub-module gcd_cycle_cnt: saturating CNT_W counter with synchronous clear and enable, exposing cnt, an eq(N) compare and an at-TIMEOUT flag.
- The top level holds the FSM, the sampled-control registers, STATUS and ELAPSED.

## Test plan

- Variable time: CT=0, OPCODE=0, core done at c=7, start at s=10 -> CORE_START@11, DONE_PULSE@19, STATUS=OK, ELAPSED=7.
- Constant time: CT=1, N=20, c=7, s=10 -> DONE_PULSE@32, STATUS=OK, ELAPSED=7. Repeat with c=3 -> DONE_PULSE still @32.
- Overrun: CT=1, N=5, c=9, s=0 -> DONE_PULSE@11, STATUS=OVERRUN, ELAPSED=9.
- Illegal opcode: OPCODE=3'd6, s=4 -> no CORE_START, DONE_PULSE@5, STATUS=ILLEGAL, BUSY high only @5.
- Timeout and ignored events: core never completes, s=0 -> DONE_PULSE@4097, STATUS=TIMEOUT. Also check that a second START_PULSE during WAIT and a stray CORE_DONE in IDLE change nothing.
- Reset mid-WAIT: start at s=0, assert RESET at cycle 5 -> IDLE at cycle 6, all outputs at reset values, no DONE_PULSE. A new start at cycle 8 behaves as in the first scenario.

Source files
------------

// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD sequencer: opcodes, FSM states, status codes
// and the default counter width.
package gcd_pkg;

    localparam int CNT_W_DEF = 12;

    localparam logic [2:0] OP_GCD     = 3'd0;
    localparam logic [2:0] OP_LCM     = 3'd1;
    localparam logic [2:0] OP_MODINV  = 3'd2;
    localparam logic [2:0] OP_COPRIME = 3'd3;
    localparam logic [2:0] OP_MAX     = 3'd3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_PAD   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [1:0] STAT_OK      = 2'd0;
    localparam logic [1:0] STAT_ILLEGAL = 2'd1;
    localparam logic [1:0] STAT_OVERRUN = 2'd2;
    localparam logic [1:0] STAT_TIMEOUT = 2'd3;

    function automatic logic op_legal(input logic [2:0] op);
        return op <= OP_MAX;
    endfunction

endpackage

// File: rtl/gcd_cycle_cnt.sv
// Saturating cycle counter with synchronous clear/enable, a target compare
// and a flag raised once the count has reached the timeout value.
module gcd_cycle_cnt
    import gcd_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int TIMEOUT = 2**CNT_W - 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] target,
    output logic [CNT_W-1:0] cnt,
    output logic             eq,
    output logic             at_max
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    // Sticks at CNT_MAX so a hung core can never wrap the count back to zero.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= sat_inc(cnt);
        end
    end

    assign eq     = (cnt == target);
    assign at_max = (cnt == CNT_MAX);

endmodule

// File: rtl/gcd_seq_ctrl.sv
// Sequencer between the register file and the GCD core: issues the core start,
// measures core latency, optionally pads to a constant cycle count.
module gcd_seq_ctrl
    import gcd_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int TIMEOUT = 2**CNT_W - 1
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START_PULSE,
    input  logic [2:0]       OPCODE,
    input  logic             CONSTANT_TIME,
    input  logic [CNT_W-1:0] CYCLE_COUNT,
    output logic             CORE_START,
    output logic [2:0]       CORE_OP,
    input  logic             CORE_DONE,
    output logic             DONE_PULSE,
    output logic             BUSY,
    output logic [1:0]       STATUS,
    output logic [CNT_W-1:0] ELAPSED
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    state_t           state;
    logic             ct_lat;
    logic [CNT_W-1:0] n_lat;
    logic [CNT_W-1:0] cnt;
    logic             cnt_eq;
    logic             cnt_at_max;
    logic             accept;
    logic             cnt_en;
    logic             pad_on;

    assign accept = (state == ST_IDLE) && START_PULSE;
    assign cnt_en = (state == ST_ISSUE) || (state == ST_WAIT) || (state == ST_PAD);
    // A zero target means "no constant-time window": no padding and no overrun.
    assign pad_on = ct_lat && (n_lat != '0);

    gcd_cycle_cnt #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) u_cnt (
        .clk    (CLK),
        .rst    (RESET),
        .clr    (accept),
        .en     (cnt_en),
        .target (n_lat),
        .cnt    (cnt),
        .eq     (cnt_eq),
        .at_max (cnt_at_max)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state      <= ST_IDLE;
            CORE_START <= 1'b0;
            CORE_OP    <= 3'd0;
            DONE_PULSE <= 1'b0;
            BUSY       <= 1'b0;
            STATUS     <= STAT_OK;
            ELAPSED    <= '0;
            ct_lat     <= 1'b0;
            n_lat      <= '0;
        end else begin
            CORE_START <= 1'b0;
            DONE_PULSE <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (START_PULSE) begin
                        CORE_OP <= OPCODE;
                        ct_lat  <= CONSTANT_TIME;
                        n_lat   <= CYCLE_COUNT;
                        STATUS  <= STAT_OK;
                        BUSY    <= 1'b1;
                        if (op_legal(OPCODE)) begin
                            CORE_START <= 1'b1;
                            state      <= ST_ISSUE;
                        end else begin
                            STATUS     <= STAT_ILLEGAL;
                            DONE_PULSE <= 1'b1;
                            state      <= ST_DONE;
                        end
                    end
                end
                ST_ISSUE: begin
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (CORE_DONE) begin
                        ELAPSED <= cnt;
                        if (pad_on && (cnt < n_lat)) begin
                            state <= ST_PAD;
                        end else begin
                            DONE_PULSE <= 1'b1;
                            state      <= ST_DONE;
                            if (pad_on && (cnt > n_lat)) begin
                                STATUS <= STAT_OVERRUN;
                            end
                        end
                    end else if (cnt_at_max) begin
                        ELAPSED    <= CNT_MAX;
                        STATUS     <= STAT_TIMEOUT;
                        DONE_PULSE <= 1'b1;
                        state      <= ST_DONE;
                    end
                end
                ST_PAD: begin
                    // The saturation exit only matters if TIMEOUT is set below the target.
                    if (cnt_eq || cnt_at_max) begin
                        DONE_PULSE <= 1'b1;
                        state      <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    BUSY  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    BUSY  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gcd_seq_ctrl.sv
// Directed bench for gcd_seq_ctrl with a tiny core model that answers
// CORE_START after a programmed number of cycles.
module tb_gcd_seq_ctrl;

    localparam int CNT_W = 12;

    logic             CLK = 1'b0;
    logic             RESET;
    logic             START_PULSE;
    logic [2:0]       OPCODE;
    logic             CONSTANT_TIME;
    logic [CNT_W-1:0] CYCLE_COUNT;
    logic             CORE_START;
    logic [2:0]       CORE_OP;
    logic             CORE_DONE;
    logic             DONE_PULSE;
    logic             BUSY;
    logic [1:0]       STATUS;
    logic [CNT_W-1:0] ELAPSED;

    int n_cmp = 0;
    int n_err = 0;

    int               cs_cyc, cs_cnt, dp_cyc, dp_cnt, busy_first, busy_last;
    logic [1:0]       dp_status;
    logic [CNT_W-1:0] dp_elapsed;
    logic [2:0]       dp_op;
    logic [19:0]      snap;

    gcd_seq_ctrl #(.CNT_W(CNT_W)) dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .START_PULSE   (START_PULSE),
        .OPCODE        (OPCODE),
        .CONSTANT_TIME (CONSTANT_TIME),
        .CYCLE_COUNT   (CYCLE_COUNT),
        .CORE_START    (CORE_START),
        .CORE_OP       (CORE_OP),
        .CORE_DONE     (CORE_DONE),
        .DONE_PULSE    (DONE_PULSE),
        .BUSY          (BUSY),
        .STATUS        (STATUS),
        .ELAPSED       (ELAPSED)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Cycle t of a run: outputs are sampled, then inputs for cycle t are driven.
    task automatic run_op(input logic [2:0] op, input logic ctv, input logic [11:0] nv,
                          input int s, input int c, input int dup, input int stray,
                          input int rst_at, input int snap_at, input int limit);
        logic pend;
        pend       = 1'b0;
        cs_cyc     = -1;
        cs_cnt     = 0;
        dp_cyc     = -1;
        dp_cnt     = 0;
        busy_first = -1;
        busy_last  = -1;
        dp_status  = 2'd0;
        dp_elapsed = '0;
        dp_op      = 3'd0;
        snap       = '1;
        for (int t = 0; t < limit; t++) begin
            if (CORE_START) begin
                cs_cnt++;
                if (cs_cyc < 0) cs_cyc = t;
                pend = 1'b1;
            end
            if (DONE_PULSE) begin
                dp_cnt++;
                dp_cyc     = t;
                dp_status  = STATUS;
                dp_elapsed = ELAPSED;
                dp_op      = CORE_OP;
            end
            if (BUSY) begin
                if (busy_first < 0) busy_first = t;
                busy_last = t;
            end
            if (t == snap_at) snap = {CORE_START, CORE_OP, DONE_PULSE, BUSY, STATUS, ELAPSED};
            START_PULSE   = (t == s) || (t == dup);
            OPCODE        = (t == s) ? op : 3'd5;
            CONSTANT_TIME = (t == s) ? ctv : ~ctv;
            CYCLE_COUNT   = (t == s) ? nv : 12'd1;
            CORE_DONE     = (pend && c > 0 && t == cs_cyc + c) || (t == stray);
            RESET         = (t == rst_at);
            if (RESET) pend = 1'b0;
            step();
        end
        START_PULSE = 1'b0;
        CORE_DONE   = 1'b0;
        RESET       = 1'b0;
    endtask

    initial begin
        RESET         = 1'b1;
        START_PULSE   = 1'b0;
        OPCODE        = 3'd0;
        CONSTANT_TIME = 1'b0;
        CYCLE_COUNT   = '0;
        CORE_DONE     = 1'b0;
        repeat (3) step();
        chk("reset_outputs", 32'({CORE_START, CORE_OP, DONE_PULSE, BUSY, STATUS, ELAPSED}), 32'd0);
        RESET = 1'b0;

        // Variable time, with a stray CORE_DONE while idle
        run_op(3'd0, 1'b0, 12'd20, 10, 7, -1, 3, -1, -1, 30);
        chk("var_core_start_cyc", cs_cyc, 11);
        chk("var_core_start_cnt", cs_cnt, 1);
        chk("var_done_cyc", dp_cyc, 19);
        chk("var_done_cnt", dp_cnt, 1);
        chk("var_status", dp_status, 0);
        chk("var_elapsed", dp_elapsed, 7);
        chk("var_busy_first", busy_first, 11);
        chk("var_busy_last", busy_last, 19);

        // Constant time, c < N, with a start attempt in the DONE cycle
        run_op(3'd3, 1'b1, 12'd20, 10, 7, 32, -1, -1, -1, 40);
        chk("ct7_done_cyc", dp_cyc, 32);
        chk("ct7_done_cnt", dp_cnt, 1);
        chk("ct7_start_cnt", cs_cnt, 1);
        chk("ct7_status", dp_status, 0);
        chk("ct7_elapsed", dp_elapsed, 7);
        chk("ct7_core_op", dp_op, 3);

        run_op(3'd0, 1'b1, 12'd20, 10, 3, -1, -1, -1, -1, 40);
        chk("ct3_done_cyc", dp_cyc, 32);
        chk("ct3_elapsed", dp_elapsed, 3);
        chk("ct3_busy_last", busy_last, 32);

        // Overrun
        run_op(3'd1, 1'b1, 12'd5, 0, 9, -1, -1, -1, -1, 20);
        chk("ovr_done_cyc", dp_cyc, 11);
        chk("ovr_status", dp_status, 2);
        chk("ovr_elapsed", dp_elapsed, 9);
        chk("ovr_core_op", dp_op, 1);

        // Illegal opcode
        run_op(3'd6, 1'b0, 12'd0, 4, 3, -1, -1, -1, -1, 12);
        chk("ill_core_start_cnt", cs_cnt, 0);
        chk("ill_done_cyc", dp_cyc, 5);
        chk("ill_status", dp_status, 1);
        chk("ill_busy_first", busy_first, 5);
        chk("ill_busy_last", busy_last, 5);

        // Timeout, with a start during WAIT and a stray CORE_DONE afterwards
        run_op(3'd2, 1'b0, 12'd0, 0, 0, 100, 4100, -1, -1, 4105);
        chk("tmo_done_cyc", dp_cyc, 4097);
        chk("tmo_done_cnt", dp_cnt, 1);
        chk("tmo_start_cnt", cs_cnt, 1);
        chk("tmo_status", dp_status, 3);
        chk("tmo_elapsed", dp_elapsed, 4095);
        chk("tmo_core_op", dp_op, 2);
        chk("tmo_busy_last", busy_last, 4097);

        // Reset mid-WAIT, then a fresh start at cycle 8
        run_op(3'd0, 1'b0, 12'd0, 0, 7, -1, -1, 5, 6, 8);
        chk("rst_snapshot", 32'(snap), 32'd0);
        chk("rst_done_cnt", dp_cnt, 0);
        chk("rst_start_cnt", cs_cnt, 1);

        run_op(3'd0, 1'b0, 12'd0, 0, 7, -1, -1, -1, -1, 14);
        chk("post_core_start_cyc", cs_cyc, 1);
        chk("post_done_cyc", dp_cyc, 9);
        chk("post_status", dp_status, 0);
        chk("post_elapsed", dp_elapsed, 7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
